// File: rtl/arcsin_pkg.sv
// Shared constants, coefficient table and FSM state type for the Q2.30
// arcsine Taylor-series evaluator and its downstream consumers.
package arcsin_pkg;

  localparam int FRAC = 30;
  localparam int KSH  = 10;

  // Taylor coefficients for x^3, x^5, x^7, x^9, scaled by 2^KSH
  localparam logic signed [31:0] K [4] = '{32'sd171, 32'sd77, 32'sd46, 32'sd31};

  localparam logic signed [31:0] ONE  = 32'sh4000_0000;
  localparam logic signed [31:0] MONE = 32'shC000_0000;

  typedef enum logic [2:0] {
    IDLE,
    SQ,
    MULP,
    MACC,
    DONE
  } state_e;

endpackage

// File: rtl/arcsin_taylor_seq_if.sv
// Operand/result stream bundle: slave side is the evaluator, master side the
// producer/consumer pair that feeds it and drains results.
interface arcsin_taylor_seq_if;

  logic        s_axis_x_tvalid;
  logic        s_axis_x_tready;
  logic [31:0] s_axis_x_tdata;
  logic        m_axis_y_tvalid;
  logic        m_axis_y_tready;
  logic [31:0] m_axis_y_tdata;
  logic        m_axis_y_tuser;

  modport slave (
    input  s_axis_x_tvalid, s_axis_x_tdata, m_axis_y_tready,
    output s_axis_x_tready, m_axis_y_tvalid, m_axis_y_tdata, m_axis_y_tuser
  );

  modport master (
    output s_axis_x_tvalid, s_axis_x_tdata, m_axis_y_tready,
    input  s_axis_x_tready, m_axis_y_tvalid, m_axis_y_tdata, m_axis_y_tuser
  );

endinterface

// File: rtl/arcsin_mulsh.sv
// Shared signed 32x32 multiplier with a selectable arithmetic right shift of
// the full 64-bit product; purely combinational.
module arcsin_mulsh #(
  parameter int SH_A = 30,
  parameter int SH_B = 10
) (
  input  logic signed [31:0] a_i,
  input  logic signed [31:0] b_i,
  input  logic               sel_b_i,
  output logic signed [31:0] y_o
);

  logic signed [63:0] prod;

  assign prod = 64'(a_i) * 64'(b_i);
  assign y_o  = 32'(sel_b_i ? (prod >>> SH_B) : (prod >>> SH_A));

endmodule

// File: rtl/arcsin_taylor_seq.sv
// Sequential arcsine: x + K2*x^3 + K3*x^5 + K4*x^7 + K5*x^9 in Q2.30, one
// multiplier time-shared across SQ/MULP/MACC steps.
module arcsin_taylor_seq #(
  parameter int FRAC = 30,
  parameter int KSH  = 10
) (
  input  logic                       clk,
  input  logic                       rst,
  arcsin_taylor_seq_if.slave         axis,
  output logic                       busy
);

  import arcsin_pkg::*;

  state_e             state_q, state_d;
  logic signed [31:0] x_q, x_d, x2_q, x2_d, p_q, p_d, acc_q, acc_d;
  logic        [1:0]  i_q, i_d;
  logic               clamp_q, clamp_d;

  logic signed [31:0] x_in, x_clamped;
  logic               x_over;
  logic signed [31:0] mul_a, mul_b, mul_y;
  logic               mul_sel_ksh;

  arcsin_mulsh #(.SH_A(FRAC), .SH_B(KSH)) u_mulsh (
    .a_i    (mul_a),
    .b_i    (mul_b),
    .sel_b_i(mul_sel_ksh),
    .y_o    (mul_y)
  );

  // Saturate the operand to [-1.0, +1.0] so the accumulator cannot overflow
  always_comb begin
    x_in      = axis.s_axis_x_tdata;
    x_clamped = x_in;
    x_over    = 1'b0;
    if (x_in > ONE) begin
      x_clamped = ONE;
      x_over    = 1'b1;
    end else if (x_in < MONE) begin
      x_clamped = MONE;
      x_over    = 1'b1;
    end
  end

  // NOTE: sequential state is updated with non-blocking assignments so every
  // register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      x_q     <= '0;
      x2_q    <= '0;
      p_q     <= '0;
      acc_q   <= '0;
      i_q     <= '0;
      clamp_q <= 1'b0;
    end else begin
      state_q <= state_d;
      x_q     <= x_d;
      x2_q    <= x2_d;
      p_q     <= p_d;
      acc_q   <= acc_d;
      i_q     <= i_d;
      clamp_q <= clamp_d;
    end
  end

  // NOTE: every comb output is given a hold/default value first so no path
  // through the case statement leaves it unassigned (which would infer a latch).
  always_comb begin
    state_d = state_q;
    x_d     = x_q;
    x2_d    = x2_q;
    p_d     = p_q;
    acc_d   = acc_q;
    i_d     = i_q;
    clamp_d = clamp_q;
    unique case (state_q)
      IDLE: if (axis.s_axis_x_tvalid) begin
        x_d     = x_clamped;
        p_d     = x_clamped;
        acc_d   = x_clamped;
        i_d     = 2'd0;
        clamp_d = x_over;
        state_d = SQ;
      end
      SQ: begin
        x2_d    = mul_y;
        state_d = MULP;
      end
      MULP: begin
        p_d     = mul_y;
        state_d = MACC;
      end
      MACC: begin
        acc_d = acc_q + mul_y;
        if (i_q == 2'd3) begin
          state_d = DONE;
        end else begin
          i_d     = i_q + 2'd1;
          state_d = MULP;
        end
      end
      DONE: if (axis.m_axis_y_tready) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    axis.s_axis_x_tready = (state_q == IDLE);
    axis.m_axis_y_tvalid = (state_q == DONE);
    axis.m_axis_y_tdata  = acc_q;
    axis.m_axis_y_tuser  = clamp_q;
    busy                 = (state_q != IDLE);
    mul_a       = x_q;
    mul_b       = x_q;
    mul_sel_ksh = 1'b0;
    case (state_q)
      MULP: begin
        mul_a = p_q;
        mul_b = x2_q;
      end
      MACC: begin
        mul_a       = K[i_q];
        mul_b       = p_q;
        mul_sel_ksh = 1'b1;
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_arcsin_taylor_seq.sv
// Self-checking bench for arcsin_taylor_seq: directed corner cases plus a
// randomized stream scored against a plain-arithmetic Taylor model.
module tb_arcsin_taylor_seq;

  logic clk;
  logic rst;
  logic busy;

  arcsin_taylor_seq_if axis ();

  arcsin_taylor_seq dut (
    .clk (clk),
    .rst (rst),
    .axis(axis),
    .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int vectors    = 0;
  int miscompares = 0;

  localparam int N_RAND = 200;

  logic [31:0] exp_data_q[$];
  bit          exp_user_q[$];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h, expected %h", tag, got, exp);
    end
  endtask

  // Direct evaluation of the truncated series: clamp, square, then four
  // power/coefficient steps, all in 64-bit signed integers.
  function automatic logic [32:0] model(input logic [31:0] xin);
    longint kk [4] = '{171, 77, 46, 31};
    longint x, x2, p, acc;
    logic [63:0] acc_bits;
    bit cl;
    x  = longint'($signed(xin));
    cl = 1'b0;
    if (x > 64'sd1073741824) begin
      x  = 64'sd1073741824;
      cl = 1'b1;
    end else if (x < -64'sd1073741824) begin
      x  = -64'sd1073741824;
      cl = 1'b1;
    end
    x2  = (x * x) >>> 30;
    p   = x;
    acc = x;
    for (int t = 0; t < 4; t++) begin
      p   = (p * x2) >>> 30;
      acc = acc + ((kk[t] * p) >>> 10);
    end
    acc_bits = acc;
    return {cl, acc_bits[31:0]};
  endfunction

  // Called at a negedge; returns at the negedge after the accepting edge.
  task automatic send(input logic [31:0] x, output bit ok);
    int n;
    n = 0;
    axis.s_axis_x_tdata  = x;
    axis.s_axis_x_tvalid = 1'b1;
    while (!axis.s_axis_x_tready && n < 2000) begin
      @(negedge clk);
      n++;
    end
    ok = axis.s_axis_x_tready;
    if (!ok) check("send_tready", 32'(axis.s_axis_x_tready), 32'd1);
    @(posedge clk);
    @(negedge clk);
    axis.s_axis_x_tvalid = 1'b0;
  endtask

  task automatic wait_result(output int k);
    k = 0;
    while (!axis.m_axis_y_tvalid && k < 50) begin
      @(negedge clk);
      k++;
    end
  endtask

  task automatic receive();
    axis.m_axis_y_tready = 1'b1;
    @(negedge clk);
    axis.m_axis_y_tready = 1'b0;
  endtask

  task automatic directed(input string tag, input logic [31:0] x,
                          input logic [31:0] exp_d, input bit exp_u);
    bit ok;
    int k;
    logic [32:0] m;
    m = model(x);
    send(x, ok);
    wait_result(k);
    check({tag, "_lat"},   32'(k), 32'd9);
    check({tag, "_data"},  axis.m_axis_y_tdata, exp_d);
    check({tag, "_user"},  32'(axis.m_axis_y_tuser), 32'(exp_u));
    check({tag, "_model"}, axis.m_axis_y_tdata, m[31:0]);
    receive();
    check({tag, "_rdy"},   32'(axis.s_axis_x_tready), 32'd1);
  endtask

  initial begin
    bit ok;
    int k;
    logic [32:0] m;

    rst                  = 1'b1;
    axis.s_axis_x_tvalid = 1'b0;
    axis.s_axis_x_tdata  = '0;
    axis.m_axis_y_tready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
    check("rst_s_tready", 32'(axis.s_axis_x_tready), 32'd1);
    check("rst_m_tvalid", 32'(axis.m_axis_y_tvalid), 32'd0);
    check("rst_tdata",    axis.m_axis_y_tdata,       32'd0);
    check("rst_tuser",    32'(axis.m_axis_y_tuser),  32'd0);
    check("rst_busy",     32'(busy),                 32'd0);

    directed("half",     32'h2000_0000, 32'h2183_3800, 1'b0);
    directed("neg_half", 32'hE000_0000, 32'hDE7C_C800, 1'b0);
    directed("one",      32'h4000_0000, 32'h5450_0000, 1'b0);
    directed("clamp_hi", 32'h7FFF_FFFF, 32'h5450_0000, 1'b1);
    directed("clamp_lo", 32'h8000_0000, 32'hABB0_0000, 1'b1);

    // Backpressure with a second operand waiting
    send(32'h0000_0000, ok);
    wait_result(k);
    check("bp_lat", 32'(k), 32'd9);
    axis.s_axis_x_tdata  = 32'h2000_0000;
    axis.s_axis_x_tvalid = 1'b1;
    for (int c = 0; c < 20; c++) begin
      check("bp_tvalid",   32'(axis.m_axis_y_tvalid), 32'd1);
      check("bp_tdata",    axis.m_axis_y_tdata,       32'd0);
      check("bp_s_tready", 32'(axis.s_axis_x_tready), 32'd0);
      @(negedge clk);
    end
    axis.m_axis_y_tready = 1'b1;
    @(negedge clk);
    axis.m_axis_y_tready = 1'b0;
    check("bp_rel_tvalid", 32'(axis.m_axis_y_tvalid), 32'd0);
    check("bp_rel_ready",  32'(axis.s_axis_x_tready), 32'd1);
    @(negedge clk);
    axis.s_axis_x_tvalid = 1'b0;
    check("bp_second_acc", 32'(busy), 32'd1);
    wait_result(k);
    check("bp_second_lat",  32'(k), 32'd9);
    check("bp_second_data", axis.m_axis_y_tdata, 32'h2183_3800);
    receive();

    // Reset in the middle of a computation
    send(32'h2000_0000, ok);
    repeat (3) @(negedge clk);
    check("mid_busy", 32'(busy), 32'd1);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    check("mid_rst_tvalid", 32'(axis.m_axis_y_tvalid), 32'd0);
    check("mid_rst_tready", 32'(axis.s_axis_x_tready), 32'd1);
    check("mid_rst_busy",   32'(busy),                 32'd0);
    check("mid_rst_tdata",  axis.m_axis_y_tdata,       32'd0);
    send(32'h0000_0000, ok);
    wait_result(k);
    check("mid_post_lat",  32'(k), 32'd9);
    check("mid_post_data", axis.m_axis_y_tdata, 32'd0);
    check("mid_post_user", 32'(axis.m_axis_y_tuser), 32'd0);
    receive();

    // Randomized stream with random downstream backpressure
    fork
      begin : producer
        int sent;
        sent = 0;
        for (int t = 0; t < N_RAND; t++) begin
          logic [31:0] x;
          longint r;
          bit pok;
          repeat ($urandom_range(2, 0)) @(negedge clk);
          if ($urandom_range(7, 0) == 0) begin
            x = $urandom;
          end else begin
            r = longint'($urandom_range(32'h8000_0000, 0)) - 64'sd1073741824;
            x = 32'(r);
          end
          m = model(x);
          send(x, pok);
          if (!pok) break;
          exp_data_q.push_back(m[31:0]);
          exp_user_q.push_back(m[32]);
          sent++;
        end
        check("rand_in_count", 32'(sent), 32'(N_RAND));
      end
      begin : consumer
        int got_n;
        int cyc;
        got_n = 0;
        cyc   = 0;
        while (got_n < N_RAND && cyc < 20000) begin
          @(negedge clk);
          cyc++;
          axis.m_axis_y_tready = 1'($urandom_range(1, 0));
          if (axis.m_axis_y_tvalid && axis.m_axis_y_tready) begin
            if (exp_data_q.size() == 0) begin
              check("rand_unexpected", 32'(axis.m_axis_y_tvalid), 32'd0);
            end else begin
              check("rand_data", axis.m_axis_y_tdata, exp_data_q.pop_front());
              check("rand_user", 32'(axis.m_axis_y_tuser), 32'(exp_user_q.pop_front()));
            end
            got_n++;
          end
        end
        @(negedge clk);
        axis.m_axis_y_tready = 1'b0;
        check("rand_out_count", 32'(got_n), 32'(N_RAND));
      end
    join

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/arcsin_taylor_seq.md
# arcsin_taylor_seq

Sequential fixed-point arcsine evaluator for the arcsin lab datapath on the Nexys4 DDR board. It accepts one Q2.30 operand over an AXI-Stream-style handshake and evaluates the 5-term Taylor series x + k2·x³ + k3·x⁵ + k4·x⁷ + k5·x⁹ with one shared multiplier. It returns Q2.30 radians to the downstream combinational/floating-point conversion stage.

## Interface
Parameters:
- FRAC, 30: fractional bits of input and output (Q2.30).
- KSH, 10: coefficient fraction bits. Coefficients are integers scaled by 2^KSH.

Ports:
- clk  in  1  system clock; all logic on the rising edge.
- rst  in  1  reset. One clock; reset is synchronous and active-high.
- s_axis_x_tvalid  in  1  operand valid.
- s_axis_x_tready  out  1  operand accepted when high together with tvalid.
- s_axis_x_tdata  in  32  signed Q2.30 operand x.
- m_axis_y_tvalid  out  1  result valid.
- m_axis_y_tready  in  1  downstream accepts result.
- m_axis_y_tdata  out  32  signed Q2.30 arcsin approximation in radians.
- m_axis_y_tuser  out  1  set when the input was clamped because |x| > 1.0.
- busy  out  1  high in any state other than IDLE.

## Operation
- Coefficients: K2=171, K3=77, K4=46, K5=31 (≈1/6, 3/40, 15/336, 105/3456, each ×1024).
- FSM states: IDLE, SQ, MULP, MACC, DONE. A 2-bit term counter i covers terms 2..5.
- IDLE:
  - s_axis_x_tready=1.
  - On handshake: clamp x to [0xC000_0000, 0x4000_0000]; set the clamp flag if clamping occurred; load p=x, acc=x, i=0; go to SQ.
- SQ: x2 = (x·x) >>> FRAC; go to MULP.
- MULP: p = (p·x2) >>> FRAC; go to MACC.
- MACC: acc = acc + ((K[i]·p) >>> KSH).
  - If i==3, go to DONE.
  - Otherwise increment i and go to MULP.
- DONE:
  - m_axis_y_tvalid=1; tdata=acc and tuser=clamp flag, both held stable.
  - On m_axis_y_tready, go to IDLE.
- Arithmetic:
  - Products are full 64-bit signed.
  - `>>>` is an arithmetic shift, truncating toward −∞.
  - acc is 32-bit with no saturation. The clamped input bounds acc to ≤ 0x5450_0000, so it cannot overflow.
- s_axis_x_tready = (state==IDLE). m_axis_y_tvalid = (state==DONE). Both are decoded from registered state.
- Input tvalid is ignored outside IDLE. Output tready is ignored outside DONE.

## Timing
- Reset values:
  - state=IDLE
  - s_axis_x_tready=1
  - m_axis_y_tvalid=0
  - m_axis_y_tdata=0
  - m_axis_y_tuser=0
  - busy=0
- Latency: for an input handshake at edge N, the result register is written at edge N+9, and m_axis_y_tvalid is high from then on. That is 1 SQ cycle plus 4×(MULP+MACC).
- The result is held indefinitely while m_axis_y_tready=0 (backpressure).
- Output handshake at edge M → state returns to IDLE, and s_axis_x_tready is high after M. There is no same-cycle accept/emit overlap. Minimum spacing between input handshakes is 11 cycles.
- rst asserted in any state, including mid-computation or in DONE with a pending result:
  - Next edge forces IDLE and discards the result (tvalid low).
  - Internal x, x2, p, acc and i are cleared.

## Structure
- Package arcsin_pkg holds:
  - FRAC and KSH constants.
  - Coefficient array K[0:3] = {171, 77, 46, 31}.
  - Clamp constants ONE=0x4000_0000 and MONE=0xC000_0000.
  - State enum typedef shared with the downstream stage's testbench.
- One sub-module, arcsin_mulsh: signed 32×32 multiply plus parameterised arithmetic right shift, combinational.
  - Instantiated once.
  - Operand muxing is done by the FSM (x·x, p·x2, K·p with shift selected by state).

## Test plan
- After reset: tready=1, tvalid=0, tdata=0. Then x=0x2000_0000 (0.5) → tvalid exactly 9 edges after accept; tdata=0x2183_3800 (≈π/6); tuser=0.
- x=0xE000_0000 (−0.5) → tdata=0xDE7C_C800; tuser=0.
- x=0x4000_0000 (1.0) → tdata=0x5450_0000, tuser=0. Then x=0x7FFF_FFFF → the same tdata with tuser=1.
- x=0 with m_axis_y_tready held low for 20 cycles:
  - tdata=0 held stable and tvalid stays high.
  - s_axis_x_tready stays 0.
  - A second input presented during that time is not accepted until the cycle after the output handshake.
- rst pulsed for 1 cycle at 4 cycles after accepting x=0x2000_0000:
  - Next edge gives tvalid=0, tready=1, busy=0.
  - A following input x=0 produces tdata=0 with the full 9-cycle latency.
- Back-to-back random |x|≤1 stream with random tready:
  - Every output equals a bit-exact reference model of the same shift/truncate sequence.
  - Input/output handshake counts match.
